// File: rtl/demux_8_2_router.sv
// ---------------------------------------------------------------------------
// demux_8_2_router
//
// Registered 1:4 byte demultiplexer. One input byte per cycle is steered by
// in_sel into one of four single-entry output buffers (A..D). Each channel
// has its own valid/ready handshake. A full channel applies backpressure only
// to inputs that target it, so the other channels keep accepting and
// draining.
//
// Parameters
//   WIDTH      data width of the input and of each output channel
//   HOLD_LAST  1: an empty channel keeps showing its last loaded byte
//              0: an empty channel drives 0
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    input byte present
//   in_ready    router can accept the input this cycle (combinational)
//   in_data     input byte
//   in_sel      target channel: 0=A, 1=B, 2=C, 3=D
//   out_valid   per-channel buffer full, bit0=A .. bit3=D
//   out_ready   per-channel sink accepts
//   A,B,C,D     channel data
//   xfer_count  number of accepted input transfers, wraps at 256
// ---------------------------------------------------------------------------
module demux_8_2_router #(
  parameter int WIDTH     = 8,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [7:0]       xfer_count
);

  localparam int NUM_CH = 4;

  logic [WIDTH-1:0] data_q [NUM_CH];
  logic [WIDTH-1:0] data_d [NUM_CH];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [7:0]       count_q;
  logic [7:0]       count_d;

  logic             accept;
  logic [3:0]       sel_onehot;
  logic [WIDTH-1:0] ch_out [NUM_CH];

  // Readiness looks only at the selected channel: it can take a byte when
  // it is empty, or when its current byte leaves on this same edge.
  assign in_ready   = !valid_q[in_sel] || out_ready[in_sel];
  assign accept     = in_valid && in_ready;
  assign sel_onehot = 4'b0001 << in_sel;

  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    for (int i = 0; i < NUM_CH; i++) begin
      data_d[i] = data_q[i];
    end

    if (accept) begin
      count_d = count_q + 8'd1;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      // A load takes priority over a drain on the same channel, so a
      // drain-and-refill edge keeps the channel valid with the new byte.
      if (accept && sel_onehot[i]) begin
        data_d[i]  = in_data;
        valid_d[i] = 1'b1;
      end else if (valid_q[i] && out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Channel output view: either the stored byte always, or the stored byte
  // only while the buffer is full.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_out
      if (HOLD_LAST) begin : g_hold
        assign ch_out[gi] = data_q[gi];
      end else begin : g_zero
        assign ch_out[gi] = valid_q[gi] ? data_q[gi] : '0;
      end
    end
  endgenerate

  assign out_valid  = valid_q;
  assign xfer_count = count_q;
  assign A          = ch_out[0];
  assign B          = ch_out[1];
  assign C          = ch_out[2];
  assign D          = ch_out[3];

endmodule
